// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter.
//   arbState_e : two-state offer FSM encoding (IDLE, OFFER)
//   N_CH_DEF   : default channel count
//   CNT_W_DEF  : default drop counter width
//   satAdd     : saturating add used by the drop counter
package edge_arb_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arbState_e;

  // Adds two counts and clamps at maxVal. The 33-bit intermediate keeps the
  // comparison correct even when a + b wraps the 32-bit range.
  function automatic logic [31:0] satAdd(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] maxVal);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, maxVal}) begin
      return maxVal;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per channel
//   ptr     : channel with highest priority this cycle
//   gnt_idx : index of the first set request at or after ptr, wrapping
//   any     : at least one request is set
module rr_pick
  import edge_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [$clog2(N_CH)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IW = $clog2(N_CH);

  logic [2*N_CH-1:0] reqDbl;
  logic [2*N_CH-1:0] maskDbl;
  logic [2*N_CH-1:0] masked;
  int                pos;

  // The request vector is duplicated and every bit below ptr is masked off.
  // The lowest surviving bit is then the first request at or after ptr. The
  // upper copy supplies the wrapped-around requests, so no separate
  // wrap-around search is needed.
  always_comb begin
    reqDbl  = {req, req};
    maskDbl = '0;
    for (int j = 0; j < 2 * N_CH; j++) begin
      maskDbl[j] = (j >= int'(ptr));
    end
    masked = reqDbl & maskDbl;
    pos    = 0;
    for (int j = 2 * N_CH - 1; j >= 0; j--) begin
      if (masked[j]) begin
        pos = j;
      end
    end
    gnt_idx = (pos >= N_CH) ? IW'(pos - N_CH) : IW'(pos);
    any     = |req;
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event collector with round-robin issue.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   x        : level inputs, already synchronous to clk
//   ev_valid : an event is being offered
//   ev_ready : the consumer accepts the offered event this cycle
//   ev_ch    : channel index of the offered event
//   ev_ovf   : further edges were merged into the offered event
//   drop_cnt : saturating count of merged (lost) edges since reset
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         x,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_ch,
  output logic                    ev_ovf,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int          IW      = $clog2(N_CH);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  arbState_e         state_q, state_d;
  logic [N_CH-1:0]   x_q;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     ev_ch_q, ev_ch_d;
  logic              ev_ovf_q, ev_ovf_d;
  logic              ev_valid_q, ev_valid_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   accMask;
  logic [N_CH-1:0]   dropMask;
  logic [31:0]       dropCount;
  logic              accept;
  logic [IW-1:0]     pickIdx;
  logic              anyPend;

  rr_pick #(
    .N_CH(N_CH)
  ) u_pick (
    .req    (pend_q),
    .ptr    (ptr_q),
    .gnt_idx(pickIdx),
    .any    (anyPend)
  );

  // The offer FSM. In IDLE it picks the next pending channel and freezes its
  // index into ev_ch; in OFFER it holds until the consumer takes the event.
  // ev_valid is registered from the next state so it never depends on
  // ev_ready combinationally and never drops without an accept.
  always_comb begin
    state_d    = state_q;
    ev_ch_d    = ev_ch_q;
    ev_ovf_d   = ev_ovf_q;
    ptr_d      = ptr_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyPend) begin
          state_d  = OFFER;
          ev_ch_d  = pickIdx;
          ev_ovf_d = ovf_q[pickIdx];
        end
      end
      OFFER: begin
        if (ev_ready) begin
          accept   = 1'b1;
          state_d  = IDLE;
          ev_ovf_d = 1'b0;
          ptr_d    = (ev_ch_q == IW'(N_CH - 1)) ? '0 : ev_ch_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ev_valid_d = (state_d == OFFER);
  end

  // Per-channel pending and overflow bookkeeping. An accept clears the
  // channel, but a rise landing in that same cycle re-arms pend as a fresh
  // event with a clean overflow flag. A rise on a channel that is already
  // pending and not being accepted is a merge: it marks overflow and is
  // counted as a dropped edge.
  always_comb begin
    rise      = x & ~x_q;
    accMask   = '0;
    for (int i = 0; i < N_CH; i++) begin
      accMask[i] = accept && (ev_ch_q == IW'(i));
    end
    dropMask  = rise & pend_q & ~accMask;
    pend_d    = (pend_q & ~accMask) | rise;
    ovf_d     = (ovf_q & ~accMask) | dropMask;
    dropCount = '0;
    for (int i = 0; i < N_CH; i++) begin
      dropCount = dropCount + 32'(dropMask[i]);
    end
    drop_cnt_d = CNT_W'(satAdd(32'(drop_cnt_q), dropCount, CNT_MAX));
  end

  // All state registers. x_q resets to ones so a line already high when
  // reset releases is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '1;
      pend_q     <= '0;
      ovf_q      <= '0;
      ptr_q      <= '0;
      ev_ch_q    <= '0;
      ev_ovf_q   <= 1'b0;
      ev_valid_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      ptr_q      <= ptr_d;
      ev_ch_q    <= ev_ch_d;
      ev_ovf_q   <= ev_ovf_d;
      ev_valid_q <= ev_valid_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // During an offer the overflow flag follows the live ovf bit so that
  // merges arriving while the consumer stalls are still reported.
  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign ev_ovf   = (state_q == OFFER) ? ovf_q[ev_ch_q] : ev_ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule
